// File: rtl/alu_result_skid_if.sv
// alu_result_skid_if: handshake, data and status bundle of the ALU result skid stage
interface alu_result_skid_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic             sticky_carry;
  logic [CNT_W-1:0] carry_cnt;
  logic             sticky_clr;
  modport master (
    output in_valid, in_result, in_carry, out_ready, sticky_clr,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_neg, sticky_carry, carry_cnt
  );
  modport slave (
    input  in_valid, in_result, in_carry, out_ready, sticky_clr,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_neg, sticky_carry, carry_cnt
  );
endinterface

// File: rtl/alu_result_skid.sv
// alu_result_skid: 2-entry skid buffer for adder results with zero/neg flags and sticky carry counter
module alu_result_skid #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_skid_if.slave    bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             neg;
  } entry_t;
  state_t           state, state_nx;
  entry_t           main_q, skid_q, in_e;
  logic             ready_q, sticky_q, acc, pop, ev;
  logic [CNT_W-1:0] cnt_q, cnt_base;
  assign acc  = bus.in_valid && ready_q;
  assign pop  = (state != EMPTY) && bus.out_ready;
  assign ev   = acc && bus.in_carry;
  assign in_e = '{bus.in_result, bus.in_carry, bus.in_result == '0, bus.in_result[WIDTH-1]};
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = acc ? ONE : EMPTY;
      ONE:     state_nx = (acc && !pop) ? TWO : (pop && !acc) ? EMPTY : ONE;
      TWO:     state_nx = pop ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= state_nx != TWO;
      if (state == TWO && pop) main_q <= skid_q;
      else if (acc && (state == EMPTY || pop)) main_q <= in_e;
      if (state == ONE && acc && !pop) skid_q <= in_e;
    end
  // clear is applied before the same-cycle carry event is counted
  assign cnt_base = bus.sticky_clr ? '0 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= ev || (sticky_q && !bus.sticky_clr);
      cnt_q    <= (ev && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
    end
  assign bus.in_ready     = ready_q;
  assign bus.out_valid    = state != EMPTY;
  assign bus.out_result   = main_q.result;
  assign bus.out_carry    = main_q.carry;
  assign bus.out_zero     = main_q.zero;
  assign bus.out_neg      = main_q.neg;
  assign bus.sticky_carry = sticky_q;
  assign bus.carry_cnt    = cnt_q;
endmodule

// File: doc/alu_result_skid.md
# alu_result_skid

Output stage directly downstream of the 32-bit carry-lookahead arithmetic unit. It captures the adder's sum and carry-out with a valid/ready handshake and decouples the combinational adder from back-pressure using a 2-entry skid buffer. It derives zero and negative flags per beat and maintains a sticky carry flag plus a saturating carry-event counter for status readback.

## Interface
- `WIDTH`, default 32: result width, matching the adder data path.
- `CNT_W`, default 8: carry-event counter width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  the adder result on `in_result`/`in_carry` is valid.
- `in_ready`  out  1  the stage accepts a beat this cycle.
- `in_result`  in  WIDTH  adder sum (`out` of the arithmetic unit).
- `in_carry`  in  1  adder carry-out (`overflow` of the arithmetic unit; unsigned carry out of bit 31).
- `out_valid`  out  1  the head beat is presented downstream.
- `out_ready`  in  1  downstream consumes the head beat this cycle.
- `out_result`  out  WIDTH  head result.
- `out_carry`  out  1  head carry-out.
- `out_zero`  out  1  head result == 0.
- `out_neg`  out  1  head result[WIDTH-1].
- `sticky_carry`  out  1  set by any accepted beat with carry = 1.
- `carry_cnt`  out  CNT_W  count of accepted beats with carry = 1, saturating.
- `sticky_clr`  in  1  synchronous clear of `sticky_carry` and `carry_cnt`.

## Operation
- Accept when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Storage:
  - Main register: the head, which drives the `out_*` ports.
  - Skid register: the second entry.
  - Each entry holds {result, carry, zero, neg}. Flags are computed from `in_result` at capture time.
- State machine, encoded by occupancy:
  - EMPTY
    - accept → ONE (load main).
  - ONE
    - accept and no pop → TWO (load skid).
    - pop and no accept → EMPTY.
    - accept and pop → ONE (load main with the new beat).
    - neither → ONE.
  - TWO
    - pop → ONE (skid moves to main).
    - `in_ready` = 0, so no accept is possible.
- `in_ready` is registered, = (next state != TWO). It is never combinationally dependent on `out_ready`.
- `out_valid` = (state != EMPTY).
- Ordering is strict FIFO. No beat is dropped or duplicated.
- While `out_valid && !out_ready`, all `out_*` ports hold stable.
- Sticky flag and counter:
  - Accepted beat with `in_carry` = 1: set `sticky_carry` and increment `carry_cnt`.
  - `carry_cnt` saturates at 2^CNT_W − 1 and never wraps.
  - `sticky_clr` with no carry event that cycle: `sticky_carry` → 0, `carry_cnt` → 0.
  - `sticky_clr` together with a carry event in the same cycle: `sticky_carry` = 1, `carry_cnt` = 1 (clear applies first, then the event is counted).
- `sticky_clr` does not affect buffered data or the handshake.
- Reset:
  - State EMPTY.
  - `in_ready` = 1, `out_valid` = 0.
  - `out_result` = 0, `out_carry` = 0, `out_zero` = 0, `out_neg` = 0.
  - `sticky_carry` = 0, `carry_cnt` = 0.
- Reset asserted mid-operation discards both entries immediately, independent of `clk`.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` with `out_valid` = 1 from edge N (registered output), i.e. visible in cycle N+1.
- Throughput: 1 beat per cycle when `out_ready` is held at 1. Occupancy stays ONE.
- Back-pressure:
  - `out_ready` deasserting while in ONE with a beat arriving → TWO.
  - `in_ready` drops one cycle later.
  - The skid entry absorbs the in-flight beat.
- Recovery: from TWO, a single pop cycle → ONE, and `in_ready` = 1 on the next cycle.
- `sticky_carry` and `carry_cnt` update on the accept edge, one cycle before the same beat could be popped.

## Test plan
- Reset, then `in_valid` = 0 → `out_valid` = 0, `in_ready` = 1, `carry_cnt` = 0, all `out_*` = 0.
- Stream 0x00000001, 0x80000000, 0x00000000 with `out_ready` = 1 → outputs appear one cycle later, in order:
  - 0x00000001: `out_zero`/`out_neg` = 0/0.
  - 0x80000000: `out_zero`/`out_neg` = 0/1.
  - 0x00000000: `out_zero`/`out_neg` = 1/0.
- Accept 0xAAAA5555, then 0x12345678 while `out_ready` = 0:
  - State reaches TWO and `in_ready` = 0.
  - Head holds 0xAAAA5555 stable.
  - Release `out_ready` → 0xAAAA5555, then 0x12345678, with no loss.
- 300 accepted beats with `in_carry` = 1 → `carry_cnt` = 255 (saturated), `sticky_carry` = 1.
- `sticky_clr` with no carry event → `carry_cnt` = 0, `sticky_carry` = 0.
- `sticky_clr` in the same cycle as an accepted carry beat → `carry_cnt` = 1, `sticky_carry` = 1.
- Assert `rst_n` = 0 asynchronously while in TWO → `out_valid` = 0 and `in_ready` = 1 without a clock edge. After release, the first new beat 0x0000BEEF is the first output.
